// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central hazard sequencer for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// It resolves load-use hazards, EX-stage branch redirects, ID-stage jumps and
// data-memory wait states into stall/flush/bubble controls. It also produces
// the EX operand forwarding selects and a performance counter of PC-stall
// cycles.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   id_rs, id_rt, id_j_op ID-stage source registers and jump flag
//   ex_rs, ex_rt          EX-stage source registers (forwarding compare)
//   ex_mem_r, ex_w_*      EX-stage load flag and destination
//   ex_branch_taken       BEQ resolved taken in EX
//   mem_w_*, wb_w_*       MEM/WB-stage destinations (forwarding sources)
//   mem_req, mem_ack      data-memory handshake
//   pc_stall .. mem_wb_bubble  pipeline register controls (combinational)
//   fwd_a_sel, fwd_b_sel  00 regfile, 01 from MEM, 10 from WB
//   stall_cycles          count of cycles with pc_stall=1 (wraps)
//   err_timeout           sticky: memory wait reached MEM_TIMEOUT cycles
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_j_op,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_r,
  input  logic             ex_w_reg_ena,
  input  logic [4:0]       ex_w_addr,
  input  logic             ex_branch_taken,
  input  logic             mem_w_reg_ena,
  input  logic [4:0]       mem_w_addr,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             wb_w_reg_ena,
  input  logic [4:0]       wb_w_addr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic               err_timeout_q, err_timeout_d;

  logic mem_hold;
  logic load_use;
  logic unused_ex_w_reg_ena;

  // A load always writes its destination, so the write enable adds nothing
  // to the load-use test.
  assign unused_ex_w_reg_ena = ex_w_reg_ena;

  assign mem_hold = mem_req && !mem_ack;
  assign load_use = ex_mem_r && (ex_w_addr != 5'd0) &&
                    ((ex_w_addr == id_rs) || (ex_w_addr == id_rt));

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_w_reg_ena && (mem_w_addr != 5'd0) && (mem_w_addr == src)) begin
      return 2'b01;
    end else if (wb_w_reg_ena && (wb_w_addr != 5'd0) && (wb_w_addr == src)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = '0;
    stall_cycles_d = stall_cycles_q;
    err_timeout_d  = err_timeout_q;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_stall   = 1'b0;
    mem_wb_bubble  = 1'b0;

    if (rst) begin
      state_d        = RUN;
      stall_cycles_d = '0;
      err_timeout_d  = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_hold) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
          end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = BR_FLUSH;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = LU_STALL;
          end else if (id_j_op) begin
            if_id_flush = 1'b1;
          end
        end
        // The load has moved on and a bubble sits in EX, so no new
        // load-use can exist; only a memory wait can act here.
        LU_STALL: begin
          if (mem_hold) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
          end else begin
            state_d = RUN;
          end
        end
        // Masks the slot that was just flushed by the branch.
        BR_FLUSH: begin
          state_d = RUN;
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state_d = RUN;
          end else begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            wait_cnt_d    = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q >= TIMEOUT_M1) begin
              err_timeout_d = 1'b1;
            end
          end
        end
        default: state_d = RUN;
      endcase

      if (pc_stall) begin
        stall_cycles_d = stall_cycles_q + 1'b1;
      end
    end
  end

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (!rst) begin
      fwd_a_sel = fwd_sel(ex_rs);
      fwd_b_sel = fwd_sel(ex_rt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_FREEZE = 7'b1101011;
  localparam logic [6:0] C_BRANCH = 7'b0010100;
  localparam logic [6:0] C_LU     = 7'b1100100;
  localparam logic [6:0] C_JUMP   = 7'b0010000;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_w_addr, mem_w_addr, wb_w_addr;
  logic id_j_op, ex_mem_r, ex_w_reg_ena, ex_branch_taken;
  logic mem_w_reg_ena, mem_req, mem_ack, wb_w_reg_ena;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles;
  logic err_timeout;

  logic [6:0] act_c;
  assign act_c = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                  ex_mem_stall, mem_wb_bubble};

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the pipeline is currently doing.
  bit             m_waiting;   // memory access outstanding
  bit             m_after_lu;  // cycle after a load-use stall
  bit             m_after_br;  // cycle after a branch flush
  int             m_wait_n;    // completed waiting cycles
  logic [CNT_W-1:0] m_stalls;
  bit             m_err;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_j_op(id_j_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_r(ex_mem_r),
    .ex_w_reg_ena(ex_w_reg_ena), .ex_w_addr(ex_w_addr),
    .ex_branch_taken(ex_branch_taken),
    .mem_w_reg_ena(mem_w_reg_ena), .mem_w_addr(mem_w_addr),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .wb_w_reg_ena(wb_w_reg_ena), .wb_w_addr(wb_w_addr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cycles(stall_cycles), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit lu_hazard();
    return ex_mem_r && ex_w_addr != 0 && (ex_w_addr == id_rs || ex_w_addr == id_rt);
  endfunction

  function automatic logic [6:0] model_ctrl();
    if (rst) return C_NONE;
    if (m_waiting) return mem_ack ? C_NONE : C_FREEZE;
    if (m_after_br) return C_NONE;
    if (mem_req && !mem_ack) return C_FREEZE;
    if (m_after_lu) return C_NONE;
    if (ex_branch_taken) return C_BRANCH;
    if (lu_hazard()) return C_LU;
    if (id_j_op) return C_JUMP;
    return C_NONE;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (rst) return 2'b00;
    if (mem_w_reg_ena && mem_w_addr != 0 && mem_w_addr == src) return 2'b01;
    if (wb_w_reg_ena && wb_w_addr != 0 && wb_w_addr == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [10:0] model_comb();
    return {model_ctrl(), model_fwd(ex_rs), model_fwd(ex_rt)};
  endfunction

  function automatic string got_str();
    return $sformatf("got ctrl=%b fa=%b fb=%b stalls=%0d err=%b",
                     act_c, fwd_a_sel, fwd_b_sel, stall_cycles, err_timeout);
  endfunction

  function automatic string want_str();
    logic [10:0] e;
    e = model_comb();
    return $sformatf("want ctrl=%b fa=%b fb=%b stalls=%0d err=%b",
                     e[10:4], e[3:2], e[1:0], m_stalls, m_err);
  endfunction

  // Advance the model across the coming clock edge, then go to the next negedge.
  task automatic tick();
    logic [6:0] c;
    c = model_ctrl();
    if (rst) begin
      m_waiting = 0; m_after_lu = 0; m_after_br = 0;
      m_wait_n = 0; m_stalls = '0; m_err = 0;
    end else begin
      if (c[6]) m_stalls = m_stalls + 1'b1;
      if (m_waiting) begin
        if (mem_ack) begin
          m_waiting = 0; m_wait_n = 0;
        end else begin
          m_wait_n++;
          if (m_wait_n >= MEM_TIMEOUT) m_err = 1;
        end
      end else if (m_after_br) begin
        m_after_br = 0;
      end else if (mem_req && !mem_ack) begin
        m_waiting = 1; m_after_lu = 0; m_wait_n = 0;
      end else if (m_after_lu) begin
        m_after_lu = 0;
      end else if (ex_branch_taken) begin
        m_after_br = 1;
      end else if (lu_hazard()) begin
        m_after_lu = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; id_rs = 0; id_rt = 0; id_j_op = 0; ex_rs = 0; ex_rt = 0;
    ex_mem_r = 0; ex_w_reg_ena = 0; ex_w_addr = 0; ex_branch_taken = 0;
    mem_w_reg_ena = 0; mem_w_addr = 0; mem_req = 0; mem_ack = 0;
    wb_w_reg_ena = 0; wb_w_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; mem_req = 1; mem_ack = 0; ex_branch_taken = 1; id_j_op = 1;
    ex_rs = 5; mem_w_reg_ena = 1; mem_w_addr = 5;
    #1; vectors++;
    if ({act_c, fwd_a_sel, fwd_b_sel} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ctrl=%b fa=%b fb=%b, want all zero", act_c, fwd_a_sel, fwd_b_sel);
    end
    tick();
    #1; vectors++;
    if (stall_cycles !== '0 || err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs: got stalls=%0d err=%b, want 0 0", stall_cycles, err_timeout);
    end
    for (int i = 0; i < 3; i++) begin
      rst = 0; ex_branch_taken = 0; id_j_op = 0;
      mem_req = (i == 0); mem_ack = (i == 2);
      #1; vectors++;
      if ({act_c, fwd_a_sel, fwd_b_sel} !== model_comb() || stall_cycles !== m_stalls || err_timeout !== m_err) begin
        miscompares++;
        $display("FAIL reset_release c%0d: %s / %s", i, got_str(), want_str());
      end
      if (i == 1) begin
        vectors++;
        if (act_c !== C_FREEZE) begin
          miscompares++;
          $display("FAIL reset_mem_wait_entered: got ctrl=%b want %b", act_c, C_FREEZE);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_r = 1; ex_w_reg_ena = 1; ex_w_addr = 2; id_rs = 2; id_rt = 7;
    for (int i = 0; i < 2; i++) begin
      #1; vectors++;
      if (act_c !== ((i == 0) ? C_LU : C_NONE)) begin
        miscompares++;
        $display("FAIL load_use c%0d: got ctrl=%b want %b", i, act_c, (i == 0) ? C_LU : C_NONE);
      end
      tick();
    end
    ex_mem_r = 0;
    #1; vectors++;
    if ({act_c, fwd_a_sel, fwd_b_sel} !== model_comb() || stall_cycles !== m_stalls || err_timeout !== m_err) begin
      miscompares++;
      $display("FAIL load_use_after: %s / %s", got_str(), want_str());
    end
    tick();
    ex_mem_r = 1; ex_w_addr = 0; id_rs = 0; id_rt = 0;
    #1; vectors++;
    if (act_c !== C_NONE) begin
      miscompares++;
      $display("FAIL load_use_r0: got ctrl=%b want %b", act_c, C_NONE);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1; ex_mem_r = 1; ex_w_addr = 3; id_rt = 3; id_j_op = 1;
    #1; vectors++;
    if (act_c !== C_BRANCH) begin
      miscompares++;
      $display("FAIL branch_over_lu: got ctrl=%b want %b", act_c, C_BRANCH);
    end
    tick();
    #1; vectors++;
    if (act_c !== C_NONE || {act_c, fwd_a_sel, fwd_b_sel} !== model_comb()) begin
      miscompares++;
      $display("FAIL branch_flush_slot: %s / %s", got_str(), want_str());
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [CNT_W-1:0] s0;
    do_reset();
    s0 = stall_cycles;
    mem_req = 1;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 4);
      #1; vectors++;
      if ({act_c, fwd_a_sel, fwd_b_sel} !== model_comb() || stall_cycles !== m_stalls || err_timeout !== m_err) begin
        miscompares++;
        $display("FAIL mem_wait c%0d: %s / %s", i, got_str(), want_str());
      end
      tick();
    end
    mem_req = 0; mem_ack = 0;
    #1; vectors++;
    if (stall_cycles - s0 !== 32'd4) begin
      miscompares++;
      $display("FAIL mem_wait_count: got %0d stall cycles, want 4", stall_cycles - s0);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i <= 20; i++) begin
      #1; vectors++;
      if (err_timeout !== (i >= MEM_TIMEOUT + 1) || {act_c, fwd_a_sel, fwd_b_sel} !== model_comb() || err_timeout !== m_err) begin
        miscompares++;
        $display("FAIL timeout c%0d: %s / %s", i, got_str(), want_str());
      end
      tick();
    end
    mem_ack = 1;
    #1; vectors++;
    if (act_c !== C_NONE || err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_ack: got ctrl=%b err=%b, want %b 1", act_c, err_timeout, C_NONE);
    end
    tick();
    mem_req = 0; mem_ack = 0;
    #1; vectors++;
    if (err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got err=%b want 1", err_timeout);
    end
    do_reset();
    #1; vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_cleared: got err=%b want 0", err_timeout);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    ex_rs = 5; mem_w_reg_ena = 1; mem_w_addr = 5; wb_w_reg_ena = 1; wb_w_addr = 5;
    #1; vectors++;
    if (fwd_a_sel !== 2'b01) begin
      miscompares++;
      $display("FAIL fwd_mem_first: got %b want 01", fwd_a_sel);
    end
    mem_w_reg_ena = 0;
    #1; vectors++;
    if (fwd_a_sel !== 2'b10) begin
      miscompares++;
      $display("FAIL fwd_wb: got %b want 10", fwd_a_sel);
    end
    ex_rs = 0; ex_rt = 0; mem_w_reg_ena = 1; mem_w_addr = 0; wb_w_addr = 0;
    #1; vectors++;
    if (fwd_b_sel !== 2'b00 || fwd_a_sel !== 2'b00) begin
      miscompares++;
      $display("FAIL fwd_r0: got a=%b b=%b want 00 00", fwd_a_sel, fwd_b_sel);
    end
    tick();
  endtask

  task automatic test_jump();
    do_reset();
    id_j_op = 1;
    #1; vectors++;
    if (act_c !== C_JUMP || pc_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL jump: got ctrl=%b want %b", act_c, C_JUMP);
    end
    tick();
    // Jump arriving with a load-use: stall first, jump is taken afterwards.
    ex_mem_r = 1; ex_w_addr = 4; id_rs = 4;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ex_mem_r = 0;
      #1; vectors++;
      if (act_c !== ((i == 0) ? C_LU : (i == 1) ? C_NONE : C_JUMP)) begin
        miscompares++;
        $display("FAIL jump_deferred c%0d: %s / %s", i, got_str(), want_str());
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst             = ($urandom_range(0, 49) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rs           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_w_addr       = 5'($urandom_range(0, 3));
      mem_w_addr      = 5'($urandom_range(0, 3));
      wb_w_addr       = 5'($urandom_range(0, 3));
      id_j_op         = ($urandom_range(0, 5) == 0);
      ex_mem_r        = ($urandom_range(0, 2) == 0);
      ex_w_reg_ena    = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_w_reg_ena   = 1'($urandom_range(0, 1));
      wb_w_reg_ena    = 1'($urandom_range(0, 1));
      mem_req         = ($urandom_range(0, 5) == 0);
      mem_ack         = ($urandom_range(0, 2) == 0);
      #1; vectors++;
      if ({act_c, fwd_a_sel, fwd_b_sel} !== model_comb() || stall_cycles !== m_stalls || err_timeout !== m_err) begin
        miscompares++;
        $display("FAIL random c%0d: %s / %s", i, got_str(), want_str());
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    tick();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_jump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Detects load-use hazards, branch/jump redirects and data-memory wait states.
- Drives the stall, flush and bubble controls for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Produces EX-stage operand forwarding selects and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM_WAIT before err_timeout asserts.
- CNT_W, 32, width of stall_cycles counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_j_op  in  1  ID holds J (resolved in ID)
- ex_rs  in  5  rs of instruction in EX
- ex_rt  in  5  rt of instruction in EX
- ex_mem_r  in  1  EX instruction is LW
- ex_w_reg_ena  in  1  EX instruction writes regfile
- ex_w_addr  in  5  EX destination register
- ex_branch_taken  in  1  BEQ in EX resolved taken
- mem_w_reg_ena  in  1  MEM instruction writes regfile
- mem_w_addr  in  5  MEM destination register
- mem_req  in  1  MEM stage issuing data-memory access
- mem_ack  in  1  data memory completes access this cycle
- wb_w_reg_ena  in  1  WB writes regfile
- wb_w_addr  in  5  WB destination register
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  load bubble into ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_bubble  out  1  load bubble into MEM/WB
- fwd_a_sel  out  2  EX operand A source
- fwd_b_sel  out  2  EX operand B source
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1
- err_timeout  out  1  sticky memory-timeout flag

Behaviour:
- States: RUN, LU_STALL, BR_FLUSH, MEM_WAIT. State register, wait counter, stall_cycles and err_timeout are registered. All other outputs are combinational from state and inputs.
- Reset (rst=1 at posedge): state=RUN, wait counter=0, stall_cycles=0, err_timeout=0. During reset cycle all control outputs=0 and fwd selects=00. Reset mid-MEM_WAIT abandons the wait.
- Priority when several conditions hold in RUN: mem wait > branch taken > load-use > jump.
- Mem wait: RUN with mem_req=1 and mem_ack=0 enters MEM_WAIT.
  - In RUN that same cycle, and in every MEM_WAIT cycle with mem_ack=0: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall=1 and mem_wb_bubble=1.
  - mem_req=1 with mem_ack=1 in the same cycle in RUN causes no stall.
  - In MEM_WAIT, mem_ack=1 releases all stalls that cycle; next state is RUN.
  - Wait counter increments each MEM_WAIT cycle. On reaching MEM_TIMEOUT, err_timeout sets and stays set until rst. State remains MEM_WAIT.
- Branch: ex_branch_taken=1 in RUN → if_id_flush=1 and id_ex_flush=1 this cycle; next state BR_FLUSH.
  - BR_FLUSH lasts one cycle with no control outputs, then returns to RUN. It exists only to mask a spurious load-use detect on the flushed slot.
- Load-use: in RUN, hazard when ex_mem_r=1, ex_w_addr≠0, and ex_w_addr matches id_rs or id_rt.
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle; next state LU_STALL.
  - LU_STALL performs no load-use detection and returns to RUN. Mem wait preempts it.
- Jump: id_j_op=1 in RUN with no higher-priority event → if_id_flush=1 for one cycle; state stays RUN.
  - A jump coincident with a load-use stall is deferred until the stall clears, because the jump stays held in ID.
- Forwarding, for operand A against ex_rs (B identical against ex_rt):
  - 01 if mem_w_reg_ena=1, mem_w_addr≠0 and matches.
  - Else 10 if wb_w_reg_ena=1, wb_w_addr≠0 and matches.
  - Else 00.
  - MEM beats WB. Forwarding is evaluated in every state.
- stall_cycles increments on each posedge where pc_stall=1 and rst=0. It wraps at 2^CNT_W−1 → 0.

Test Plan:
- Reset with mem_req=1: all controls 0, stall_cycles=0, err_timeout=0. After release with mem_ack=0, MEM_WAIT entered next cycle.
- LW $2 in EX (ex_mem_r=1, ex_w_addr=2, ex_w_reg_ena=1) with id_rs=2: one cycle of pc_stall/if_id_stall/id_ex_flush=1, then RUN. Same stimulus with ex_w_addr=0: no stall.
- ex_branch_taken=1 together with a load-use match: only if_id_flush and id_ex_flush=1 (no stall). Next cycle BR_FLUSH with all controls 0.
- mem_req=1, mem_ack low for 3 cycles then high: pipeline frozen for exactly 3 cycles plus the entry cycle, stall_cycles=4. With MEM_TIMEOUT=16 and ack withheld for 20 cycles: err_timeout=1 from cycle 16 and held after ack.
- ex_rs=5, mem_w_addr=5 and wb_w_addr=5 both writing: fwd_a_sel=01. Disable the mem write: 10. ex_rt=0 with all writers at addr 0: fwd_b_sel=00.
- id_j_op=1 in RUN: if_id_flush=1 for one cycle, pc_stall=0.
